// File: rtl/tl_reg_slave.sv
// rtl/tl_reg_slave.sv - TileLink-UL register slave: 16 x 64-bit registers, single-slot D response (optional checks: TL_REG_SLAVE_ERRCHK_EN)
module tl_reg_slave #(
    parameter logic [31:0] BASE_ADDR = 32'h1000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        a_valid,
    output logic        a_ready,
    input  logic [2:0]  a_opcode,
    input  logic [2:0]  a_param,
    input  logic [3:0]  a_size,
    input  logic [2:0]  a_source,
    input  logic [31:0] a_address,
    input  logic [63:0] a_data,
    input  logic        a_corrupt,
    output logic        d_valid,
    input  logic        d_ready,
    output logic [2:0]  d_opcode,
    output logic [1:0]  d_param,
    output logic [3:0]  d_size,
    output logic [2:0]  d_source,
    output logic        d_denied,
    output logic [63:0] d_data,
    output logic        d_corrupt
);

    localparam logic [2:0] OP_PUT_FULL = 3'd0;
    localparam logic [2:0] OP_GET      = 3'd4;
    localparam logic [2:0] OP_ACK      = 3'd0;
    localparam logic [2:0] OP_ACK_DATA = 3'd1;

    logic [63:0] r_regs [16];

    logic        r_d_valid;
    logic [2:0]  r_d_opcode;
    logic [3:0]  r_d_size;
    logic [2:0]  r_d_source;
    logic        r_d_denied;
    logic [63:0] r_d_data;

    logic        w_a_fire;
    logic        w_d_fire;
    logic [3:0]  w_index;
    logic        w_is_get;
    logic        w_denied;
    logic        w_write;
    logic [1:0]  w_size_eff;
    logic [2:0]  w_off;
    logic [7:0]  w_bytes;
    logic [15:0] w_lane_wide;
    logic [7:0]  w_lanes;
    logic [63:0] w_wmask;
    logic [63:0] w_rsp_data;
    logic        w_unused;

    assign a_ready  = ~r_d_valid | d_ready;
    assign w_a_fire = a_valid & a_ready;
    assign w_d_fire = r_d_valid & d_ready;
    assign w_index  = a_address[6:3];
    assign w_is_get = (a_opcode == OP_GET);

`ifdef TL_REG_SLAVE_ERRCHK_EN
    logic [2:0] w_align_mask;

    // Low address bits that must be zero for a naturally aligned access of this size
    always_comb begin
        w_align_mask = 3'b000;
        case (a_size[1:0])
            2'd0:    w_align_mask = 3'b000;
            2'd1:    w_align_mask = 3'b001;
            2'd2:    w_align_mask = 3'b011;
            default: w_align_mask = 3'b111;
        endcase
    end

    // Any malformed request is denied: it gets an error response and never touches storage
    always_comb begin
        w_denied = 1'b0;
        if ((a_opcode != OP_PUT_FULL) && (a_opcode != OP_GET))
            w_denied = 1'b1;
        if (a_size > 4'd3)
            w_denied = 1'b1;
        if ((a_address[2:0] & w_align_mask) != 3'b000)
            w_denied = 1'b1;
        if (a_address[31:7] != BASE_ADDR[31:7])
            w_denied = 1'b1;
        if ((a_opcode == OP_PUT_FULL) && a_corrupt)
            w_denied = 1'b1;
    end

    assign w_unused = ^{a_param};
`else
    assign w_denied = 1'b0;
    assign w_unused = ^{a_param, a_address[31:7], a_corrupt};
`endif

    // Oversized requests collapse to a full 8-byte access starting at lane 0
    always_comb begin
        if (a_size > 4'd3) begin
            w_size_eff = 2'd3;
            w_off      = 3'd0;
        end else begin
            w_size_eff = a_size[1:0];
            w_off      = a_address[2:0];
        end
    end

    // Byte-lane enable: 2^size contiguous lanes starting at the address offset
    always_comb begin
        w_bytes = 8'h00;
        case (w_size_eff)
            2'd0:    w_bytes = 8'h01;
            2'd1:    w_bytes = 8'h03;
            2'd2:    w_bytes = 8'h0F;
            default: w_bytes = 8'hFF;
        endcase
        w_lane_wide = {8'h00, w_bytes} << w_off;
        w_lanes     = w_lane_wide[7:0];
    end

    // Expand lane enables into a per-bit write mask
    always_comb begin
        w_wmask = '0;
        for (int b = 0; b < 8; b++) begin
            w_wmask[b*8 +: 8] = {8{w_lanes[b]}};
        end
    end

    assign w_write    = w_a_fire & ~w_is_get & ~w_denied;
    assign w_rsp_data = (w_is_get & ~w_denied) ? r_regs[w_index] : 64'd0;

    // Register file: cleared by reset, partial writes merge only the enabled byte lanes
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_write) begin
            r_regs[w_index] <= (r_regs[w_index] & ~w_wmask) | (a_data & w_wmask);
        end
    end

    // Single response slot: a new request replaces it, a bare D-fire empties it
    always_ff @(posedge clock) begin
        if (reset) begin
            r_d_valid  <= 1'b0;
            r_d_opcode <= '0;
            r_d_size   <= '0;
            r_d_source <= '0;
            r_d_denied <= 1'b0;
            r_d_data   <= '0;
        end else if (w_a_fire) begin
            r_d_valid  <= 1'b1;
            r_d_opcode <= w_is_get ? OP_ACK_DATA : OP_ACK;
            r_d_size   <= a_size;
            r_d_source <= a_source;
            r_d_denied <= w_denied;
            r_d_data   <= w_rsp_data;
        end else if (w_d_fire) begin
            r_d_valid  <= 1'b0;
        end
    end

    assign d_valid   = r_d_valid;
    assign d_opcode  = r_d_opcode;
    assign d_param   = 2'd0;
    assign d_size    = r_d_size;
    assign d_source  = r_d_source;
    assign d_denied  = r_d_denied;
    assign d_data    = r_d_data;
    assign d_corrupt = 1'b0;

endmodule

// File: tb/tb_tl_reg_slave.sv
// tb/tb_tl_reg_slave.sv - self-checking bench for tl_reg_slave (honours TL_REG_SLAVE_ERRCHK_EN)
module tb_tl_reg_slave;

    localparam logic [31:0] BASE = 32'h1000_0000;

    logic        clock = 1'b0;
    logic        reset;
    logic        a_valid;
    logic        a_ready;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [3:0]  a_size;
    logic [2:0]  a_source;
    logic [31:0] a_address;
    logic [63:0] a_data;
    logic        a_corrupt;
    logic        d_valid;
    logic        d_ready;
    logic [2:0]  d_opcode;
    logic [1:0]  d_param;
    logic [3:0]  d_size;
    logic [2:0]  d_source;
    logic        d_denied;
    logic [63:0] d_data;
    logic        d_corrupt;

    tl_reg_slave #(.BASE_ADDR(BASE)) dut (
        .clock(clock), .reset(reset),
        .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode), .a_param(a_param),
        .a_size(a_size), .a_source(a_source), .a_address(a_address), .a_data(a_data),
        .a_corrupt(a_corrupt),
        .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode), .d_param(d_param),
        .d_size(d_size), .d_source(d_source), .d_denied(d_denied), .d_data(d_data),
        .d_corrupt(d_corrupt)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [2:0]  op;
        logic [3:0]  size;
        logic [2:0]  src;
        logic        den;
        logic [63:0] data;
    } resp_t;

    resp_t       q[$];
    resp_t       last_exp;
    logic [63:0] mem [16];
    int          checks = 0;
    int          failures = 0;
    int          npops = 0;
    int          cyc = 0;
    int          last_pop_cyc = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < 16; i++) mem[i] = 64'd0;
    endtask

    function automatic resp_t model(input logic [2:0] op, input logic [3:0] size, input logic [2:0] src,
                                    input logic [31:0] addr, input logic [63:0] data, input logic corrupt);
        resp_t      r;
        logic       den;
        logic       is_get;
        int         nb;
        int         off;
        logic [3:0] idx;
        is_get = (op == 3'd4);
        idx    = addr[6:3];
        den    = 1'b0;
`ifdef TL_REG_SLAVE_ERRCHK_EN
        if (op != 3'd0 && op != 3'd4) den = 1'b1;
        if (size > 4'd3) den = 1'b1;
        else if ((int'(addr[2:0]) % (1 << int'(size))) != 0) den = 1'b1;
        if (addr[31:7] != BASE[31:7]) den = 1'b1;
        if (op == 3'd0 && corrupt) den = 1'b1;
`else
        if (corrupt) den = 1'b0;
`endif
        r.op   = is_get ? 3'd1 : 3'd0;
        r.size = size;
        r.src  = src;
        r.den  = den;
        r.data = (is_get && !den) ? mem[idx] : 64'd0;
        if (!is_get && !den) begin
            if (size > 4'd3) begin
                nb  = 8;
                off = 0;
            end else begin
                nb  = 1 << int'(size);
                off = int'(addr[2:0]);
            end
            for (int b = 0; b < 8; b++) begin
                if (b >= off && b < off + nb) mem[idx][b*8 +: 8] = data[b*8 +: 8];
            end
        end
        return r;
    endfunction

    task automatic send(input logic [2:0] op, input logic [3:0] size, input logic [2:0] src,
                        input logic [31:0] addr, input logic [63:0] data, input logic corrupt);
        logic fired;
        a_opcode  = op;
        a_param   = 3'($urandom_range(0, 7));
        a_size    = size;
        a_source  = src;
        a_address = addr;
        a_data    = data;
        a_corrupt = corrupt;
        a_valid   = 1'b1;
        last_exp  = model(op, size, src, addr, data, corrupt);
        q.push_back(last_exp);
        fired = 1'b0;
        for (int i = 0; i < 50 && !fired; i++) begin
            @(negedge clock);
            fired = a_ready;
            @(posedge clock);
            #1;
        end
        a_valid = 1'b0;
        check("a_accept", fired, 1);
    endtask

    task automatic idle(input int n);
        a_valid = 1'b0;
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Scoreboard: every D-fire pops one expected response
    always @(negedge clock) begin
        resp_t exp;
        if (!reset && d_valid && d_ready) begin
            check("resp_expected", q.size() != 0, 1);
            if (q.size() != 0) begin
                exp = q.pop_front();
                check("resp", {d_opcode, d_param, d_size, d_source, d_denied, d_corrupt, d_data},
                              {exp.op, 2'b00, exp.size, exp.src, exp.den, 1'b0, exp.data});
                npops++;
                last_pop_cyc = cyc;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int base_pops;
        logic [63:0] wdata;

        reset = 1'b1; a_valid = 1'b0; a_opcode = '0; a_param = '0; a_size = '0;
        a_source = '0; a_address = '0; a_data = '0; a_corrupt = 1'b0; d_ready = 1'b1;
        clear_model();
        repeat (3) @(posedge clock);
        #1;
        @(negedge clock);
        check("reset_d_valid", d_valid, 0);
        check("reset_d_outs", {d_opcode, d_param, d_size, d_source, d_denied, d_corrupt, d_data}, 0);
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        check("a_ready_after_reset", a_ready, 1);
        @(posedge clock); #1;

        // Full put then get of the same word, then a single-byte merge
        send(3'd0, 4'd3, 3'd1, 32'h1000_0018, 64'h1122_3344_5566_7788, 1'b0);
        send(3'd4, 4'd3, 3'd2, 32'h1000_0018, 64'd0, 1'b0);
        send(3'd0, 4'd0, 3'd3, 32'h1000_001B, 64'h0000_0000_AA00_0000, 1'b0);
        send(3'd4, 4'd3, 3'd4, 32'h1000_0018, 64'd0, 1'b0);
        check("merge_model", mem[3], 64'h1122_3344_AA66_7788);
        send(3'd0, 4'd1, 3'd0, 32'h1000_0022, 64'h0000_0000_BEEF_0000, 1'b0);
        send(3'd4, 4'd3, 3'd1, 32'h1000_0020, 64'd0, 1'b0);

        // Back-pressure: response held stable, A blocked, then replaced with no gap
        idle(2);
        d_ready = 1'b0;
        send(3'd4, 4'd3, 3'd5, 32'h1000_0018, 64'd0, 1'b0);
        a_opcode = 3'd0; a_size = 4'd2; a_source = 3'd6; a_address = 32'h1000_0030;
        a_data = 64'h0000_0000_CAFE_F00D; a_corrupt = 1'b0; a_valid = 1'b1;
        q.push_back(model(3'd0, 4'd2, 3'd6, 32'h1000_0030, 64'h0000_0000_CAFE_F00D, 1'b0));
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("stall_d_valid", d_valid, 1);
            check("stall_d_data", {d_opcode, d_source, d_data}, {last_exp.op, 3'd5, last_exp.data});
            check("stall_a_ready", a_ready, 0);
            @(posedge clock); #1;
        end
        d_ready = 1'b1;
        @(negedge clock);
        check("release_a_ready", a_ready, 1);
        @(posedge clock); #1;
        a_valid = 1'b0;
        @(negedge clock);
        check("no_gap_d_valid", d_valid, 1);
        @(posedge clock); #1;
        send(3'd4, 4'd2, 3'd7, 32'h1000_0030, 64'd0, 1'b0);

`ifdef TL_REG_SLAVE_ERRCHK_EN
        send(3'd4, 4'd3, 3'd1, 32'h2000_0000, 64'd0, 1'b0);
        send(3'd0, 4'd2, 3'd2, 32'h1000_0002, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        send(3'd4, 4'd3, 3'd3, 32'h1000_0000, 64'd0, 1'b0);
        send(3'd0, 4'd3, 3'd4, 32'h1000_0040, 64'h5555_5555_5555_5555, 1'b1);
        send(3'd2, 4'd3, 3'd5, 32'h1000_0040, 64'h6666_6666_6666_6666, 1'b0);
        send(3'd4, 4'd5, 3'd6, 32'h1000_0040, 64'd0, 1'b0);
        send(3'd4, 4'd3, 3'd7, 32'h1000_0040, 64'd0, 1'b0);
`else
        send(3'd4, 4'd3, 3'd1, 32'h2000_0000, 64'd0, 1'b0);
        send(3'd2, 4'd5, 3'd2, 32'h1000_0045, 64'h0102_0304_0506_0708, 1'b1);
        send(3'd4, 4'd3, 3'd3, 32'h1000_0040, 64'd0, 1'b0);
        send(3'd0, 4'd3, 3'd4, 32'h7000_0008, 64'hDEAD_BEEF_0000_1111, 1'b0);
        send(3'd4, 4'd3, 3'd5, 32'h1000_0008, 64'd0, 1'b0);
`endif

        // Streaming: 16 puts then 16 gets with continuous valid/ready
        idle(3);
        c0 = cyc;
        base_pops = npops;
        for (int i = 0; i < 16; i++) begin
            wdata = {$urandom, $urandom};
            send(3'd0, 4'd3, 3'(i), BASE + 32'(i * 8), wdata, 1'b0);
        end
        for (int i = 0; i < 16; i++) begin
            send(3'd4, 4'd3, 3'(i), BASE + 32'(i * 8), 64'd0, 1'b0);
        end
        for (int i = 0; i < 100 && npops < base_pops + 32; i++) begin
            @(posedge clock); #1;
        end
        check("stream_count", npops - base_pops, 32);
        check("stream_cycles", last_pop_cyc - c0, 32);

        // Reset while a response is stalled drops it; a write during reset is discarded
        idle(2);
        d_ready = 1'b0;
        send(3'd4, 4'd3, 3'd2, 32'h1000_0018, 64'd0, 1'b0);
        reset = 1'b1;
        q.delete();
        clear_model();
        @(posedge clock); #1;
        @(negedge clock);
        check("reset_drop_d_valid", d_valid, 0);
        check("reset_drop_d_data", d_data, 0);
        a_opcode = 3'd0; a_size = 4'd3; a_address = 32'h1000_0018;
        a_data = 64'hFFFF_0000_FFFF_0000; a_corrupt = 1'b0; a_valid = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        a_valid = 1'b0;
        d_ready = 1'b1;
        send(3'd4, 4'd3, 3'd3, 32'h1000_0018, 64'd0, 1'b0);
        idle(3);
        check("scoreboard_empty", q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
